switch_bcd_display: RTL
=======================

SWITCH_BCD_DISPLAY -- requirements
Module: switch_bcd_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: switch/LED bit count, range 1..16.
REQ-002 The block SHALL have parameter DIGITS, default 2: display digit count; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a switch value, ≥1.
REQ-004 The block SHALL have parameter REFRESH_CYCLES, default 8: cycles each digit stays selected, ≥1.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 The block SHALL have port sw, input, WIDTH: raw asynchronous switch inputs.
REQ-008 The block SHALL have port led, output, WIDTH: accepted (debounced) switch value.
REQ-009 The block SHALL have port seg, output, 7: segments, seg[0]=a … seg[6]=g, active-high.
REQ-010 The block SHALL have port an, output, DIGITS: one-hot active-high digit select, an[0]=least significant digit.
REQ-011 The block SHALL have port busy, output, 1: conversion in progress.

Function
REQ-012 The block SHALL pass sw through a 2-flop synchroniser before any other use.
REQ-013 The block SHALL count consecutive cycles in which the synchronised value is unchanged, restarting the count on any change, and accept the value when the count reaches DEBOUNCE_CYCLES.
REQ-014 The block SHALL drive led from the accepted-value register, updated on the acceptance cycle.
REQ-015 The block SHALL start a conversion when the accepted value differs from the last converted value and the FSM is IDLE.
REQ-016 The FSM SHALL have states IDLE, CONV and DONE: IDLE→CONV on start; CONV lasts exactly WIDTH cycles performing one double-dabble step per cycle (add 3 to each BCD nibble ≥5, then shift left one bit); CONV→DONE; DONE lasts 1 cycle, loads the display register and records the last converted value; DONE→IDLE.
REQ-017 busy SHALL be high in CONV and DONE and low in IDLE; the display register SHALL update WIDTH+1 cycles after conversion start.
REQ-018 A value accepted while busy SHALL be held as pending (only the latest is kept) and SHALL start conversion on the cycle after DONE, so no accepted value is lost and the final display matches the final accepted value.
REQ-019 The block SHALL advance a refresh counter every cycle; on reaching REFRESH_CYCLES-1 it SHALL wrap to 0 and rotate an to the next digit, wrapping from digit DIGITS-1 to digit 0.
REQ-020 seg SHALL be the combinational 7-segment decode of the display-register digit selected by an (0=0111111, 1=0000110, 3=1001111, 5=1101101, 7=0000111, 9=1101111); BCD codes 10–15 SHALL decode to 0000000.
REQ-021 The display register SHALL not change during CONV, so seg never shows partial results.

Reset
REQ-022 While rst is high, led, accepted, pending, last-converted and display registers SHALL be 0, the FSM SHALL be IDLE, busy SHALL be 0, an SHALL be one-hot digit 0, refresh and debounce counters SHALL be 0, and seg SHALL be 0111111.
REQ-023 Reset asserted mid-conversion SHALL abandon the conversion; no display update or pending start SHALL occur after release.
REQ-024 After reset the accepted value equals the last converted value (0), so no conversion SHALL start until a non-zero value is accepted.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined, seg SHALL be 0000000 for any selected digit other than digit 0 whose value and all more-significant digit values are 0; without it, all digits SHALL display normally, zeros included.

Verification
REQ-026 Defaults; sw=1101 held → led=1101 6 cycles after the change, busy high 5 cycles, then digit0 seg=1001111, digit1 seg=0000110.
REQ-027 sw pulses 0000→0110→0000 for 3 cycles → led, busy, seg unchanged.
REQ-028 Accept 1001, then accept 1111 during CONV → busy stays high through both conversions; display ends showing 15.
REQ-029 rst pulsed during CONV of 1100 → all outputs at reset values; display stays 00.
REQ-030 sw=0111 accepted → digit1 seg=0000000 with LEADING_ZERO_BLANK_EN, 0111111 without; digit0 seg=0000111 in both.
REQ-031 After reset, no switch activity → an=01 cycles 0–7, 10 cycles 8–15, 01 at cycle 16.

Source files
------------

// File: rtl/switch_bcd_display.sv
// switch_bcd_display: debounced switch capture, LED mirror, sequential
// double-dabble binary-to-BCD conversion and a multiplexed 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks non-significant leading
// zero digits (digit 0 always shows its value).
module switch_bcd_display #(
  parameter int WIDTH           = 4,
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sw,
  output logic [WIDTH-1:0]  led,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + WIDTH;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RF_W  = $clog2(REFRESH_CYCLES + 1);
  localparam int ST_W  = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[WIDTH+4*d +: 4] >= 4'd5) begin
        t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4] + 4'd3;
      end else begin
        t[WIDTH+4*d +: 4] = t[WIDTH+4*d +: 4];
      end
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

  // BCD digit to active-high segments {g,f,e,d,c,b,a}; invalid codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_accepted;
  logic [DB_W-1:0]  r_db_cnt;
  logic             w_accept;

  state_t           r_state;
  logic [SH_W-1:0]  r_shift;
  logic [ST_W-1:0]  r_step;
  logic [WIDTH-1:0] r_conv_val, r_last, r_pending;
  logic             r_pend_vld;
  logic [BCD_W-1:0] r_disp;
  logic             w_start;
  logic [WIDTH-1:0] w_start_val;

  logic [RF_W-1:0]   r_ref_cnt;
  logic [IDX_W-1:0]  r_dig_idx;
  logic [IDX_W-1:0]  w_next_idx;
  logic [DIGITS-1:0] r_an;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [6:0]        w_seg;

  // Accept pulse: the synchronised value has now been stable for DEBOUNCE_CYCLES edges.
  always_comb begin
    w_accept = 1'b0;
    if (r_sync2 == r_cand) begin
      w_accept = (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    end else begin
      w_accept = (DEBOUNCE_CYCLES == 1);
    end
  end

  // Two-flop synchroniser, stability counter and accepted-value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cand     <= '0;
      r_db_cnt   <= '0;
      r_accepted <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_cand) begin
        if (r_db_cnt < DB_W'(DEBOUNCE_CYCLES)) begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_cand   <= r_sync2;
        r_db_cnt <= DB_W'(1);
      end
      if (w_accept) begin
        r_accepted <= r_sync2;
      end
    end
  end

  // Conversion start: new accepted value from IDLE, or a pending value right after DONE.
  always_comb begin
    w_start     = 1'b0;
    w_start_val = r_accepted;
    case (r_state)
      S_IDLE: begin
        if (r_accepted != r_last) begin
          w_start = 1'b1;
        end else begin
          w_start = 1'b0;
        end
      end
      S_DONE: begin
        if (r_pend_vld && (r_pending != r_conv_val)) begin
          w_start     = 1'b1;
          w_start_val = r_pending;
        end else begin
          w_start = 1'b0;
        end
      end
      default: w_start = 1'b0;
    endcase
  end

  // Conversion FSM: IDLE -> CONV (WIDTH steps) -> DONE (load display) -> IDLE/CONV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_step     <= '0;
      r_conv_val <= '0;
      r_last     <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
      r_disp     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_CONV: begin
          r_shift <= dabble_step(r_shift);
          if (r_step == ST_W'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_step <= r_step + ST_W'(1);
          end
        end
        S_DONE: begin
          r_disp  <= r_shift[SH_W-1:WIDTH];
          r_last  <= r_conv_val;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start) begin
        r_state    <= S_CONV;
        r_shift    <= {{BCD_W{1'b0}}, w_start_val};
        r_step     <= '0;
        r_conv_val <= w_start_val;
        r_pend_vld <= 1'b0;
      end
      // A value accepted while busy is remembered; the latest one wins.
      if (w_accept && (r_state != S_IDLE)) begin
        r_pending  <= r_sync2;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Next digit index for the refresh rotation, wrapping after the top digit.
  always_comb begin
    w_next_idx = '0;
    if (r_dig_idx == IDX_W'(DIGITS - 1)) begin
      w_next_idx = '0;
    end else begin
      w_next_idx = r_dig_idx + IDX_W'(1);
    end
  end

  // Refresh counter and one-hot digit select rotation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt <= '0;
      r_dig_idx <= '0;
      r_an      <= DIGITS'(1);
    end else begin
      if (r_ref_cnt == RF_W'(REFRESH_CYCLES - 1)) begin
        r_ref_cnt <= '0;
        r_dig_idx <= w_next_idx;
        r_an      <= DIGITS'(1) << w_next_idx;
      end else begin
        r_ref_cnt <= r_ref_cnt + RF_W'(1);
      end
    end
  end

  // Segment decode of the currently selected display digit.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_dig_idx == IDX_W'(d)) begin
        w_digit = r_disp[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (d > 0) && ((r_disp >> (4 * d)) == '0);
`else
        w_blank = 1'b0;
`endif
      end else begin
        w_digit = w_digit;
      end
    end
    if (w_blank) begin
      w_seg = 7'b0000000;
    end else begin
      w_seg = seg7(w_digit);
    end
  end

  assign led  = r_accepted;
  assign an   = r_an;
  assign seg  = w_seg;
  assign busy = (r_state != S_IDLE);

endmodule
